ftb_assoc_table: RTL and testbench
==================================

FTB_ASSOC_TABLE -- requirements
Module: ftb_assoc_table

Interface
REQ-001 SHALL have parameter SETS, default 64, number of sets, power of two >= 2.
REQ-002 SHALL have parameter WAYS, default 4, ways per set, power of two >= 2.
REQ-003 SHALL have parameter TAG_W, default `FTB_TAG_WIDTH, stored tag width.
REQ-004 SHALL have parameter FETCH_BYTES, default 32, fall-through stride on miss.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- i_flush  in  1  invalidate all entries.
- i_lookup_req  in  1  lookup request.
- i_lookup_pc  in  XLEN  fetch-block start address.
- o_lookup_rdy  out  1  table ready; low during init.
- o_lookup_vld  out  1  lookup result valid.
- o_lookup_hit  out  1  tag hit.
- o_lookup_info  out  ftbInfo_t  hit entry info, zero on miss.
- o_lookup_taken  out  1  predicted taken, equal to counter[1] & hit.
- o_lookup_npc  out  XLEN  predicted next PC.
- i_update_vld  in  1  update request.
- i_update_pc  in  XLEN  start address being trained.
- i_update_info  in  ftbInfo_t  new entry contents.
- i_update_taken  in  1  resolved direction.

Function
REQ-007 SHALL index with pc[IDX_W:1], IDX_W = log2(SETS), and tag with pc[IDX_W+TAG_W:IDX_W+1].
REQ-008 SHALL hold SETS x WAYS entries of {vld, tag, ftbInfo_t} in flops, plus one tree-PLRU of WAYS-1 bits per set.
REQ-009 SHALL use states INIT and READY. Reset or i_flush enters INIT. INIT clears one set per cycle (vld=0, PLRU=0) for SETS cycles, then enters READY.
REQ-010 SHALL drive o_lookup_rdy = 1 only in READY; lookups and updates are ignored while it is 0.
REQ-011 Lookup latency SHALL be 1 cycle: a request accepted at cycle t gives o_lookup_vld=1 at t+1 for exactly one cycle, with results taken from table state before any cycle-t update.
REQ-012 SHALL set o_lookup_npc to one of three values:
- hit & taken: target computed from the start pc, targetAddr and tarStat, as for FIT/OVF/UDF.
- hit & !taken: {pc[XLEN-1:FALLTHRU_W+1]+carry, fallthruAddr, 0}.
- miss: (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES.
All arithmetic SHALL be modulo 2^XLEN.
REQ-013 A lookup hit SHALL mark the hit way most-recent in that set's PLRU at cycle t.
REQ-014 An update SHALL compare tags combinationally at cycle t and write at the edge ending cycle t.
- On tag hit: overwrite that way with i_update_info; the counter saturates up (taken) or down from the stored value (3 up stays 3, 0 down stays 0).
- On miss: allocate the lowest-index invalid way, else the PLRU victim; counter = taken ? 2 : 1.
REQ-015 The updated or allocated way SHALL become most-recent in the PLRU. When a lookup and an update touch the same set in the same cycle, the update touch SHALL be applied last.
REQ-016 A set SHALL never hold two valid ways with equal tags.
REQ-017 i_flush at cycle t SHALL force o_lookup_vld=0 at t+1 and drop any same-cycle update. i_flush during INIT SHALL restart the sweep from set 0.

Reset
REQ-018 While rst=0, the block SHALL drive:
- o_lookup_rdy, o_lookup_vld, o_lookup_hit, o_lookup_taken = 0.
- o_lookup_info, o_lookup_npc = 0.
- FSM = INIT, sweep counter = 0.
REQ-019 After rst deasserts, o_lookup_rdy SHALL rise exactly SETS cycles later (64 cycles at default).
REQ-020 Reset asserted mid-lookup SHALL discard the pending result; no o_lookup_vld is produced.

Verification
REQ-021 Init: release rst, then drive i_lookup_req=1 every cycle -> o_lookup_rdy=0 and o_lookup_vld=0 for 64 cycles, rdy=1 on cycle 64.
REQ-022 Miss/allocate: lookup pc=0x1000 -> hit=0, npc=0x1020. Then update pc=0x1000, taken=1, targetAddr encoding 0x2000 FIT. A lookup at the next cycle -> hit=1, counter=2, taken=1, npc=0x2000.
REQ-023 Counter saturation: update the same pc with taken=0 three times -> counter 1,0,0; lookup -> taken=0, npc = fall-through address.
REQ-024 Replacement: write 5 distinct tags into set 0 (WAYS=4) with no intervening lookups -> the first tag is evicted and misses; the other four hit.
REQ-025 Same-cycle conflict: lookup and update of the same new pc in one cycle -> result miss (old state); a lookup next cycle hits.
REQ-026 Flush: i_flush while a lookup is in flight -> o_lookup_vld=0 next cycle, rdy low for 64 cycles, then all prior entries miss.

Source files
------------

// File: rtl/ftb_assoc_table.sv
// FTB set-associative table: flop ways, tree-PLRU replacement,
// one-cycle lookup with next-PC prediction and in-place training.
`ifndef FTB_TAG_WIDTH
`define FTB_TAG_WIDTH 20
`endif

package ftb_pkg;
  localparam int XLEN       = 32;
  localparam int TARGET_W   = 20;
  localparam int FALLTHRU_W = 4;

  typedef enum logic [1:0] {
    TAR_FIT = 2'd0,
    TAR_OVF = 2'd1,
    TAR_UDF = 2'd2
  } tarStat_t;

  typedef struct packed {
    logic [TARGET_W-1:0]   targetAddr;
    tarStat_t              tarStat;
    logic [FALLTHRU_W-1:0] fallthruAddr;
    logic                  carry;
    logic [1:0]            counter;
  } ftbInfo_t;
endpackage

module ftb_assoc_table
  import ftb_pkg::*;
#(
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int TAG_W       = `FTB_TAG_WIDTH,
  parameter int FETCH_BYTES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_lookup_req,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_rdy,
  output logic            o_lookup_vld,
  output logic            o_lookup_hit,
  output ftbInfo_t        o_lookup_info,
  output logic            o_lookup_taken,
  output logic [XLEN-1:0] o_lookup_npc,
  input  logic            i_update_vld,
  input  logic [XLEN-1:0] i_update_pc,
  input  ftbInfo_t        i_update_info,
  input  logic            i_update_taken
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int UP_W  = XLEN - TARGET_W - 1;
  localparam int FT_W  = XLEN - FALLTHRU_W - 1;

  typedef enum logic {INIT, READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [SETS-1:0][WAYS-1:0] vld_q;
  logic [SETS-1:0][WAYS-2:0] plru_q, plru_d;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  ftbInfo_t                  info_q [SETS][WAYS];

  logic             rdy, lk_acc, up_en;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_free;
  logic [WAY_W-1:0] lk_way, up_way, hit_way, free_way;
  logic [1:0]       old_ctr, new_ctr;
  ftbInfo_t         lk_info, up_new;
  logic             unused_pc;

  // Each node bit points at the subtree holding the victim.
  function automatic logic [WAYS-2:0] plru_touch(
    logic [WAYS-2:0] t, logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r;
    int n;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[n] = ~w[WAY_W-1-l];
      n = 2*n + 1 + int'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(
    logic [WAYS-2:0] t);
    logic [WAY_W-1:0] v;
    logic b;
    int n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = t[n];
      v[WAY_W-1-l] = b;
      n = 2*n + 1 + int'(b);
    end
    return v;
  endfunction

  function automatic logic [XLEN-1:0] pred_npc(
    logic [XLEN-1:0] pc, logic hit, ftbInfo_t inf);
    logic [UP_W-1:0] up;
    logic [FT_W-1:0] ft;
    logic [XLEN-1:0] npc;
    up = pc[XLEN-1:TARGET_W+1];
    ft = pc[XLEN-1:FALLTHRU_W+1] + FT_W'(inf.carry);
    if (!hit) begin
      npc = (pc & ~XLEN'(FETCH_BYTES-1)) + XLEN'(FETCH_BYTES);
    end else if (inf.counter[1]) begin
      unique case (inf.tarStat)
        TAR_OVF: up = up + UP_W'(1);
        TAR_UDF: up = up - UP_W'(1);
        default: ;
      endcase
      npc = {up, inf.targetAddr, 1'b0};
    end else begin
      npc = {ft, inf.fallthruAddr, 1'b0};
    end
    return npc;
  endfunction

  assign rdy    = (state_q == READY);
  assign lk_acc = i_lookup_req & rdy & ~i_flush;
  assign up_en  = i_update_vld & rdy & ~i_flush;
  assign lk_idx = i_lookup_pc[IDX_W:1];
  assign lk_tag = i_lookup_pc[IDX_W+TAG_W:IDX_W+1];
  assign up_idx = i_update_pc[IDX_W:1];
  assign up_tag = i_update_pc[IDX_W+TAG_W:IDX_W+1];
  assign unused_pc = ^{i_update_pc[XLEN-1:IDX_W+TAG_W+1],
                       i_update_pc[0]};

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (i_flush) begin
      state_d = INIT;
      sweep_d = '0;
    end else if (state_q == INIT) begin
      sweep_d = sweep_q + IDX_W'(1);
      if (sweep_q == IDX_W'(SETS-1)) state_d = READY;
    end
  end

  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    lk_info = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit  = 1'b1;
        lk_way  = WAY_W'(w);
        lk_info = info_q[lk_idx][w];
      end
    end
  end

  always_comb begin
    up_hit   = 1'b0;
    up_free  = 1'b0;
    hit_way  = '0;
    free_way = '0;
    old_ctr  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit  = 1'b1;
        hit_way = WAY_W'(w);
        old_ctr = info_q[up_idx][w].counter;
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!vld_q[up_idx][w]) begin
        up_free  = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    up_way = up_hit  ? hit_way  :
             up_free ? free_way : plru_victim(plru_q[up_idx]);
    if (up_hit && i_update_taken)
      new_ctr = (old_ctr == 2'd3) ? 2'd3 : old_ctr + 2'd1;
    else if (up_hit)
      new_ctr = (old_ctr == 2'd0) ? 2'd0 : old_ctr - 2'd1;
    else
      new_ctr = i_update_taken ? 2'd2 : 2'd1;
    up_new = i_update_info;
    up_new.counter = new_ctr;
  end

  // Update touch lands after the lookup touch on a shared set.
  always_comb begin
    plru_d = plru_q;
    if (state_q == INIT) begin
      plru_d[sweep_q] = '0;
    end else begin
      if (lk_acc && lk_hit)
        plru_d[lk_idx] = plru_touch(plru_d[lk_idx], lk_way);
      if (up_en)
        plru_d[up_idx] = plru_touch(plru_d[up_idx], up_way);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      plru_q <= '0;
    end else begin
      plru_q <= plru_d;
      if (state_q == INIT)
        vld_q[sweep_q] <= '0;
      else if (up_en)
        vld_q[up_idx][up_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (up_en) begin
      tag_q[up_idx][up_way]  <= up_tag;
      info_q[up_idx][up_way] <= up_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_lookup_vld   <= 1'b0;
      o_lookup_hit   <= 1'b0;
      o_lookup_info  <= '0;
      o_lookup_taken <= 1'b0;
      o_lookup_npc   <= '0;
    end else begin
      o_lookup_vld   <= lk_acc;
      o_lookup_hit   <= lk_acc & lk_hit;
      o_lookup_info  <= lk_acc ? lk_info : '0;
      o_lookup_taken <= lk_acc & lk_hit & lk_info.counter[1];
      o_lookup_npc   <= lk_acc ?
        pred_npc(i_lookup_pc, lk_hit, lk_info) : '0;
    end
  end

  assign o_lookup_rdy = rdy;

endmodule

// File: tb/tb_ftb_assoc_table.sv
// Bench for ftb_assoc_table: directed scenarios plus a randomized
// phase checked against an associative-array table model.
module tb_ftb_assoc_table;
  import ftb_pkg::*;

  localparam int SETS  = 64;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = `FTB_TAG_WIDTH;
  localparam int FETCH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_lookup_req;
  logic [31:0] i_lookup_pc;
  logic        o_lookup_rdy;
  logic        o_lookup_vld;
  logic        o_lookup_hit;
  ftbInfo_t    o_lookup_info;
  logic        o_lookup_taken;
  logic [31:0] o_lookup_npc;
  logic        i_update_vld;
  logic [31:0] i_update_pc;
  ftbInfo_t    i_update_info;
  logic        i_update_taken;

  int checks = 0;
  int failures = 0;
  int init_left;
  ftbInfo_t mtab [int];

  logic        lvld, lhit, ltaken;
  ftbInfo_t    linfo;
  logic [31:0] lnpc;
  logic [31:0] pool [16];

  ftb_assoc_table dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_lookup_req(i_lookup_req), .i_lookup_pc(i_lookup_pc),
    .o_lookup_rdy(o_lookup_rdy), .o_lookup_vld(o_lookup_vld),
    .o_lookup_hit(o_lookup_hit), .o_lookup_info(o_lookup_info),
    .o_lookup_taken(o_lookup_taken), .o_lookup_npc(o_lookup_npc),
    .i_update_vld(i_update_vld), .i_update_pc(i_update_pc),
    .i_update_info(i_update_info), .i_update_taken(i_update_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int key_of(logic [31:0] pc);
    logic [31:0] tag, set;
    tag = (pc >> (IDX_W+1)) % (32'd1 << TAG_W);
    set = (pc >> 1) % SETS;
    return int'(tag * SETS + set);
  endfunction

  function automatic logic [31:0] model_npc(logic [31:0] pc, bit hit,
                                            ftbInfo_t inf);
    logic [31:0] base;
    if (!hit) return (pc / FETCH) * FETCH + FETCH;
    if (inf.counter >= 2) begin
      base = pc >> (TARGET_W+1);
      if (inf.tarStat == TAR_OVF) base = base + 1;
      else if (inf.tarStat == TAR_UDF) base = base - 1;
      return (base << (TARGET_W+1)) + (32'(inf.targetAddr) << 1);
    end
    base = (pc >> (FALLTHRU_W+1)) + 32'(inf.carry);
    return (base << (FALLTHRU_W+1)) + (32'(inf.fallthruAddr) << 1);
  endfunction

  function automatic ftbInfo_t rand_info();
    ftbInfo_t f;
    f.targetAddr   = TARGET_W'($urandom);
    f.tarStat      = tarStat_t'(2'($urandom_range(0, 2)));
    f.fallthruAddr = FALLTHRU_W'($urandom);
    f.carry        = 1'($urandom);
    f.counter      = 2'($urandom);
    return f;
  endfunction

  task automatic cyc(input bit lk, input logic [31:0] lpc,
                     input bit up, input logic [31:0] upc,
                     input ftbInfo_t uinf, input bit utk,
                     input bit fl);
    bit rdy_e, acc, ehit;
    ftbInfo_t einf, ni;
    logic [31:0] enpc;
    int k, c;
    rdy_e = (init_left == 0);
    chk("rdy", o_lookup_rdy, rdy_e);
    acc  = lk && rdy_e && !fl;
    k    = key_of(lpc);
    ehit = acc && mtab.exists(k);
    einf = ehit ? mtab[k] : '0;
    enpc = acc ? model_npc(lpc, ehit, einf) : '0;
    i_lookup_req   = lk;
    i_lookup_pc    = lpc;
    i_update_vld   = up;
    i_update_pc    = upc;
    i_update_info  = uinf;
    i_update_taken = utk;
    i_flush        = fl;
    if (up && rdy_e && !fl) begin
      k  = key_of(upc);
      ni = uinf;
      if (mtab.exists(k)) begin
        c = int'(mtab[k].counter);
        c = utk ? ((c + 1 > 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        ni.counter = 2'(c);
      end else begin
        ni.counter = utk ? 2'd2 : 2'd1;
      end
      mtab[k] = ni;
    end
    if (fl) begin
      mtab.delete();
      init_left = SETS;
    end else if (init_left > 0) begin
      init_left--;
    end
    @(posedge clk);
    #1;
    i_lookup_req = 1'b0;
    i_update_vld = 1'b0;
    i_flush      = 1'b0;
    chk("vld", o_lookup_vld, acc);
    chk("hit", o_lookup_hit, ehit);
    chk("info", o_lookup_info, einf);
    chk("taken", o_lookup_taken, ehit && einf.counter >= 2);
    chk("npc", o_lookup_npc, enpc);
    lvld   = o_lookup_vld;
    lhit   = o_lookup_hit;
    ltaken = o_lookup_taken;
    linfo  = o_lookup_info;
    lnpc   = o_lookup_npc;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input ftbInfo_t f,
                        input bit tk);
    cyc(1'b0, '0, 1'b1, pc, f, tk, 1'b0);
  endtask

  initial begin
    ftbInfo_t f0, fx;
    rst = 1'b0;
    i_flush = 1'b0;
    i_lookup_req = 1'b0;
    i_lookup_pc = '0;
    i_update_vld = 1'b0;
    i_update_pc = '0;
    i_update_info = '0;
    i_update_taken = 1'b0;
    init_left = SETS;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", o_lookup_rdy, 1'b0);
    chk("rst_vld", o_lookup_vld, 1'b0);
    chk("rst_hit", o_lookup_hit, 1'b0);
    chk("rst_taken", o_lookup_taken, 1'b0);
    chk("rst_info", o_lookup_info, '0);
    chk("rst_npc", o_lookup_npc, '0);
    rst = 1'b1;

    for (int c = 0; c < SETS; c++) lookup(32'h1000);
    chk("init_rdy_up", o_lookup_rdy, 1'b1);

    f0.targetAddr   = TARGET_W'(32'h1000);
    f0.tarStat      = TAR_FIT;
    f0.fallthruAddr = 4'hA;
    f0.carry        = 1'b1;
    f0.counter      = 2'd0;
    lookup(32'h1000);
    chk("alloc_miss_hit", lhit, 1'b0);
    chk("alloc_miss_npc", lnpc, 32'h1020);
    update(32'h1000, f0, 1'b1);
    lookup(32'h1000);
    chk("alloc_hit", lhit, 1'b1);
    chk("alloc_ctr", linfo.counter, 2'd2);
    chk("alloc_taken", ltaken, 1'b1);
    chk("alloc_npc", lnpc, 32'h2000);

    for (int i = 0; i < 3; i++) begin
      update(32'h1000, f0, 1'b0);
      lookup(32'h1000);
      chk("sat_ctr", linfo.counter, (i == 0) ? 2'd1 : 2'd0);
    end
    chk("sat_taken", ltaken, 1'b0);
    chk("sat_npc", lnpc, 32'h1034);

    fx = rand_info();
    cyc(1'b1, 32'h3002, 1'b1, 32'h3002, fx, 1'b1, 1'b0);
    chk("conflict_old", lhit, 1'b0);
    lookup(32'h3002);
    chk("conflict_new", lhit, 1'b1);

    for (int i = 0; i < 16; i++) begin
      pool[i] = ($urandom << 27)
              | ((($urandom % 65536) * 16 + i) << (IDX_W+1))
              | ((2 + i / 4) << 1);
    end
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom), pool[$urandom % 16],
          1'($urandom), pool[$urandom % 16],
          rand_info(), 1'($urandom), 1'b0);
    end

    cyc(1'b1, 32'h1000, 1'b1, 32'h5000, f0, 1'b1, 1'b1);
    chk("flush_vld", lvld, 1'b0);
    for (int c = 0; c < SETS; c++) lookup(32'h1000);
    lookup(32'h1000);
    chk("flush_miss", lhit, 1'b0);
    lookup(32'h3002);
    lookup(32'h5000);
    for (int i = 0; i < 16; i++) lookup(pool[i]);

    for (int t = 1; t <= 5; t++) update(32'(t) << (IDX_W+1), rand_info(), 1'b1);
    mtab.delete(key_of(32'd1 << (IDX_W+1)));
    for (int t = 1; t <= 5; t++) begin
      lookup(32'(t) << (IDX_W+1));
      chk("repl_hit", lhit, t != 1);
    end

    i_lookup_req = 1'b1;
    i_lookup_pc  = 32'd2 << (IDX_W+1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_vld", o_lookup_vld, 1'b0);
    chk("rst_mid_rdy", o_lookup_rdy, 1'b0);
    chk("rst_mid_npc", o_lookup_npc, '0);
    i_lookup_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
